// File: rtl/controlador_execucao_if.sv
// Processor-side run handshake: Run enable out to the core, Done pulse and Tstep back.
interface controlador_execucao_if;
    logic       Run;
    logic       Done;
    logic [2:0] Tstep;

    modport master (output Run, input Done, input Tstep);
    modport slave  (input Run, output Done, output Tstep);
endinterface

// File: rtl/controlador_execucao.sv
// Run control for the multicycle core: debounced single-step, budgeted continuous run, watchdog; outputs registered.
// No backpressure; a step press outside IDLE/STOP is dropped. `define BREAK_PC_EN adds a PC breakpoint.
module controlador_execucao #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 8,
    parameter int CNT_W           = 16
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Key_step,
    input  logic                   Mode_cont,
    input  logic                   Halt_req,
    input  logic [CNT_W-1:0]       Instr_limit,
    controlador_execucao_if.master proc,
`ifdef BREAK_PC_EN
    input  logic [5:0]             Pc,
    input  logic [5:0]             Break_addr,
    input  logic                   Break_en,
`endif
    output logic                   Busy,
    output logic                   Stopped,
    output logic                   Fault,
    output logic [CNT_W-1:0]       Instr_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP,
        STOP,
        FAULT
    } state_t;

    state_t          state;
    state_t          next_state;

    logic            key_sync1;
    logic            key_sync2;
    logic            key_level;
    logic            step_pulse;
    logic [DB_W-1:0] db_cnt;

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_inc;
    logic            wd_expired;

    logic            mode_q;
    logic            halt_pend;
    logic            halt_now;
    logic            budget_hit;
    logic            run_q;

    // The debounced level only moves after a full run of samples that disagree with it.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            key_sync1  <= 1'b0;
            key_sync2  <= 1'b0;
            key_level  <= 1'b0;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            key_sync1  <= Key_step;
            key_sync2  <= key_sync1;
            step_pulse <= 1'b0;
            if (key_sync2 == key_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_level  <= key_sync2;
                db_cnt     <= '0;
                step_pulse <= key_sync2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign wd_inc     = wd_cnt + WD_W'(1);
    assign wd_expired = (wd_inc == WD_W'(TIMEOUT_CYCLES));
    // A halt seen any time during the instruction is honoured at its GAP.
    assign halt_now   = Halt_req | halt_pend;
    assign budget_hit = (Instr_limit != '0) && (Instr_count >= Instr_limit);

`ifdef BREAK_PC_EN
    logic brk_hit;
    assign brk_hit = Break_en && (Pc == Break_addr);
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (step_pulse || (Mode_cont && !Halt_req)) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (proc.Done) begin
                    next_state = GAP;
                end else if (wd_expired) begin
                    next_state = FAULT;
                end
            end
            GAP: begin
                // A core still mid-instruction after a Run-low cycle is broken.
                if (proc.Tstep != 3'd0) begin
                    next_state = FAULT;
                end else if (halt_now) begin
                    next_state = STOP;
`ifdef BREAK_PC_EN
                end else if (brk_hit) begin
                    next_state = STOP;
`endif
                end else if (mode_q && budget_hit) begin
                    next_state = STOP;
                end else if (mode_q) begin
                    next_state = ISSUE;
                end else begin
                    next_state = IDLE;
                end
            end
            STOP: begin
                if (step_pulse) begin
                    next_state = IDLE;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status flops are loaded from next_state so they line up with the state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            run_q       <= 1'b0;
            Busy        <= 1'b0;
            Stopped     <= 1'b0;
            Fault       <= 1'b0;
            Instr_count <= '0;
            wd_cnt      <= '0;
            mode_q      <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            run_q   <= (next_state == ISSUE) || (next_state == WAIT_DONE);
            Busy    <= (next_state == ISSUE) || (next_state == WAIT_DONE);
            Stopped <= (next_state == STOP);
            Fault   <= (next_state == FAULT);

            if (state == IDLE && next_state == ISSUE) begin
                mode_q <= Mode_cont;
            end

            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT_DONE) begin
                wd_cnt <= wd_inc;
            end

            if (state == WAIT_DONE && proc.Done && (Instr_count != '1)) begin
                Instr_count <= Instr_count + CNT_W'(1);
            end

            if (next_state == ISSUE || next_state == WAIT_DONE || next_state == GAP) begin
                halt_pend <= halt_pend | Halt_req;
            end else begin
                halt_pend <= 1'b0;
            end
        end
    end

    assign proc.Run = run_q;

endmodule

// File: tb/tb_controlador_execucao.sv
// Bench for controlador_execucao: processor model answers Run with Done; scoreboard checks each instruction and status snapshots.
module tb_controlador_execucao;
    localparam int CNT_W = 16;

    logic             Clock       = 1'b0;
    logic             Resetn      = 1'b0;
    logic             Key_step    = 1'b0;
    logic             Mode_cont   = 1'b0;
    logic             Halt_req    = 1'b0;
    logic [CNT_W-1:0] Instr_limit = '0;
    logic             Busy;
    logic             Stopped;
    logic             Fault;
    logic [CNT_W-1:0] Instr_count;

    logic             model_done  = 1'b0;
    logic             stray_done  = 1'b0;
    logic [2:0]       model_tstep = 3'd0;
    int               done_delay  = 3;
`ifdef BREAK_PC_EN
    logic [5:0]       Pc          = 6'd0;
    logic [5:0]       Break_addr  = 6'd0;
    logic             Break_en    = 1'b0;
`endif

    controlador_execucao_if pif();
    assign pif.Done  = model_done | stray_done;
    assign pif.Tstep = model_tstep;

    controlador_execucao #(
        .DEBOUNCE_CYCLES(16),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (CNT_W)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Key_step   (Key_step),
        .Mode_cont  (Mode_cont),
        .Halt_req   (Halt_req),
        .Instr_limit(Instr_limit),
        .proc       (pif.master),
`ifdef BREAK_PC_EN
        .Pc         (Pc),
        .Break_addr (Break_addr),
        .Break_en   (Break_en),
`endif
        .Busy       (Busy),
        .Stopped    (Stopped),
        .Fault      (Fault),
        .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string name;
        int    run_len;
        int    gap;
        int    count;
        bit    stopped;
        bit    fault;
    } run_exp_t;

    typedef struct {
        string name;
        bit    run;
        bit    busy;
        bit    stopped;
        bit    fault;
        int    count;
    } snap_exp_t;

    run_exp_t  run_q[$];
    snap_exp_t snap_q[$];
    int        checks = 0;
    int        passes = 0;
    event      snap_ev;

    // Processor model: Done is raised on the done_delay-th Run-high cycle after ISSUE (0 = never).
    initial begin : proc_model
        int k;
        k = 0;
        forever begin
            @(negedge Clock);
            model_done = 1'b0;
`ifdef BREAK_PC_EN
            if (!Resetn) Pc = 6'd0;
`endif
            if (pif.Run && Resetn) begin
`ifdef BREAK_PC_EN
                if (k == 0) Pc = Pc + 6'd1;
`endif
                if (done_delay != 0 && k == done_delay) model_done = 1'b1;
                model_tstep = (k < 6) ? 3'(k + 1) : 3'd7;
                k++;
            end else begin
                k = 0;
                model_tstep = 3'd0;
            end
        end
    end

    // Instruction monitor: each Run high->low transition is one instruction to score.
    initial begin : run_mon
        bit       prev;
        int       run_len;
        int       low_len;
        int       gap_before;
        run_exp_t e;
        prev = 1'b0; run_len = 0; low_len = 0; gap_before = -1;
        forever begin
            @(negedge Clock);
            if (!Resetn) begin
                prev = 1'b0; run_len = 0; low_len = 0; gap_before = -1;
            end else if (pif.Run) begin
                if (!prev) gap_before = (low_len > 0) ? low_len : -1;
                run_len++;
                prev = 1'b1;
            end else begin
                if (prev) begin
                    checks++;
                    if (run_q.size() == 0) begin
                        $display("FAIL unexpected_instr: len=%0d cnt=%0d, required no instruction",
                                 run_len, int'(Instr_count));
                    end else begin
                        e = run_q.pop_front();
                        if (run_len == e.run_len && (e.gap < 0 || gap_before == e.gap) &&
                            int'(Instr_count) == e.count && Stopped == e.stopped && Fault == e.fault)
                            passes++;
                        else
                            $display("FAIL %s: got len=%0d gap=%0d cnt=%0d stop=%0b fault=%0b, required len=%0d gap=%0d cnt=%0d stop=%0b fault=%0b",
                                     e.name, run_len, gap_before, int'(Instr_count), Stopped, Fault,
                                     e.run_len, e.gap, e.count, e.stopped, e.fault);
                    end
                    run_len = 0;
                    low_len = 1;
                end else if (low_len > 0) begin
                    low_len++;
                end
                prev = 1'b0;
            end
        end
    end

    initial begin : snap_mon
        snap_exp_t s;
        forever begin
            @(snap_ev);
            checks++;
            if (snap_q.size() == 0) begin
                $display("FAIL unexpected_snapshot: no expectation queued");
            end else begin
                s = snap_q.pop_front();
                if (pif.Run == s.run && Busy == s.busy && Stopped == s.stopped &&
                    Fault == s.fault && int'(Instr_count) == s.count)
                    passes++;
                else
                    $display("FAIL %s: got run=%0b busy=%0b stop=%0b fault=%0b cnt=%0d, required run=%0b busy=%0b stop=%0b fault=%0b cnt=%0d",
                             s.name, pif.Run, Busy, Stopped, Fault, int'(Instr_count),
                             s.run, s.busy, s.stopped, s.fault, s.count);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic exp_run(input string nm, input int len, input int gap, input int cnt,
                           input bit st, input bit f);
        run_exp_t e;
        e.name = nm; e.run_len = len; e.gap = gap; e.count = cnt; e.stopped = st; e.fault = f;
        run_q.push_back(e);
    endtask

    task automatic snap(input string nm, input bit r, input bit b, input bit st, input bit f,
                        input int cnt);
        snap_exp_t s;
        s.name = nm; s.run = r; s.busy = b; s.stopped = st; s.fault = f; s.count = cnt;
        snap_q.push_back(s);
        -> snap_ev;
        #1;
    endtask

    task automatic press_key(input int glitches);
        for (int g = 0; g < glitches; g++) begin
            Key_step = 1'b1; cyc(1);
            Key_step = 1'b0; cyc(2);
        end
        Key_step = 1'b1; cyc(20);
        Key_step = 1'b0; cyc(24);
    endtask

    task automatic wait_drain(input int max, input string nm);
        int n;
        n = 0;
        while (run_q.size() != 0 && n < max) begin
            cyc(1);
            n++;
        end
        if (run_q.size() != 0) begin
            checks++;
            $display("FAIL %s_timeout: %0d instructions pending, required 0", nm, run_q.size());
            run_q.delete();
        end
    endtask

    task automatic wait_run(input bit level, input int max, input string nm);
        int n;
        n = 0;
        while (pif.Run != level && n < max) begin
            cyc(1);
            n++;
        end
        if (pif.Run != level) begin
            checks++;
            $display("FAIL %s_wait: Run=%0b, required %0b within %0d cycles", nm, pif.Run, level, max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        Resetn = 1'b0;
        cyc(3);
        snap("reset", 0, 0, 0, 0, 0);
        Resetn = 1'b1;
        cyc(2);

        // Single step through a bouncing key; stray Done in IDLE must not count.
        done_delay = 3;
        exp_run("step1", 4, -1, 1, 0, 0);
        press_key(3);
        wait_drain(50, "step1");
        cyc(5);
        snap("step_idle", 0, 0, 0, 0, 1);
        stray_done = 1'b1; cyc(1); stray_done = 1'b0; cyc(2);
        snap("stray_done", 0, 0, 0, 0, 1);

        // Continuous run with a budget of five.
        Resetn = 1'b0;
        cyc(2);
        for (int i = 1; i <= 5; i++)
            exp_run($sformatf("budget%0d", i), 4, (i == 1) ? -1 : 1, i, 0, 0);
        Instr_limit = 16'd5;
        Mode_cont   = 1'b1;
        Resetn      = 1'b1;
        wait_drain(100, "budget");
        cyc(3);
        snap("budget_stop", 0, 0, 1, 0, 5);
        Mode_cont = 1'b0;
        press_key(0);
        snap("stop_to_idle", 0, 0, 0, 0, 5);

        // Reset while the instruction is still waiting for Done.
        done_delay = 0;
        Key_step   = 1'b1;
        wait_run(1'b1, 40, "abort");
        cyc(3);
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        snap("reset_abort", 0, 0, 0, 0, 0);
        Key_step = 1'b0;
        cyc(3);
        Resetn = 1'b1;
        cyc(4);

        // Watchdog: no Done at all, then the key must be ignored.
        exp_run("watchdog", 9, -1, 0, 0, 1);
        press_key(0);
        wait_drain(60, "watchdog");
        press_key(0);
        snap("fault_sticky", 0, 0, 0, 1, 0);

        // Done on the very cycle the watchdog would expire.
        Resetn = 1'b0; cyc(2); Resetn = 1'b1; cyc(2);
        done_delay = 8;
        exp_run("done_at_timeout", 9, -1, 1, 0, 0);
        press_key(0);
        wait_drain(60, "done_at_timeout");
        cyc(2);
        snap("no_fault", 0, 0, 0, 0, 1);

        // Halt pulse during the second instruction's WAIT_DONE.
        Resetn = 1'b0;
        cyc(2);
        done_delay  = 3;
        Instr_limit = '0;
        Mode_cont   = 1'b1;
        exp_run("halt1", 4, -1, 1, 0, 0);
        exp_run("halt2", 4, 1, 2, 0, 0);
        Resetn = 1'b1;
        wait_run(1'b1, 20, "halt_first");
        wait_run(1'b0, 20, "halt_gap");
        wait_run(1'b1, 20, "halt_second");
        cyc(1);
        Halt_req = 1'b1; cyc(1); Halt_req = 1'b0;
        wait_drain(40, "halt");
        cyc(3);
        snap("halt_stop", 0, 0, 1, 0, 2);
        Mode_cont = 1'b0;

`ifdef BREAK_PC_EN
        // PC breakpoint at address 3 in continuous mode.
        Resetn = 1'b0;
        cyc(2);
        Break_en   = 1'b1;
        Break_addr = 6'd3;
        Mode_cont  = 1'b1;
        for (int i = 1; i <= 3; i++)
            exp_run($sformatf("brk%0d", i), 4, (i == 1) ? -1 : 1, i, 0, 0);
        Resetn = 1'b1;
        wait_drain(80, "brk");
        cyc(3);
        snap("break_stop", 0, 0, 1, 0, 3);
        Mode_cont = 1'b0;
        Break_en  = 1'b0;
`endif

        cyc(5);
        checks++;
        if (run_q.size() == 0 && snap_q.size() == 0)
            passes++;
        else
            $display("FAIL leftover: %0d instr and %0d snapshots pending, required 0",
                     run_q.size(), snap_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
